// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch with PC, prefetch FIFO, redirect and halt
// Optional IF_FETCH_CNT_EN: count of instructions pushed into the prefetch FIFO.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             IM_read,
  output logic [IM_AW-1:0] IM_addr,
  input  logic [31:0]      IM_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic [31:0]      fetch_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {WAIT, RUN, HALT} state_t;

  state_t          state, state_next;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic [31:0]     fifo_inst [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];
  logic            pop, push;
  logic [1:0]      unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];

  // All outputs are forced idle while reset is held, whatever the registered state.
  always_comb begin
    out_valid = rst && (count != '0);
    pop       = out_valid && out_ready;
    IM_read   = rst && (state == RUN) && !redirect && ((count < FULL) || pop);
    push      = IM_read;
    IM_addr   = (rst && (state != WAIT)) ? pc[IM_AW+1:2] : '0;
    out_inst  = out_valid ? fifo_inst[rd_ptr] : 32'h0;
    out_pc    = out_valid ? fifo_pc[rd_ptr]   : 32'h0;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT:    state_next = RUN;
      RUN:     if (halt_req && !redirect) state_next = HALT;
      HALT:    if (redirect) state_next = RUN;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= WAIT;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        // A taken branch discards everything buffered, including a same-cycle pop.
        pc     <= {redirect_pc[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= IM_out;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst)      cnt <= 32'h0;
    else if (push) cnt <= cnt + 32'd1;
  end
  assign fetch_cnt = cnt;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit (vectors, corner sequences, random vs model)
module tb_if_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        IM_read;
  logic [9:0]  IM_addr;
  logic [31:0] IM_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  assign IM_out = 32'h1000_0000 + {22'b0, IM_addr};

  if_fetch_unit #(.RESET_PC(RESET_PC), .IM_AW(10), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .IM_out(IM_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req), .fetch_cnt(fetch_cnt)
  );

  // Reference model: buffered {inst, pc} pairs, current PC, started/halted flags.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_started, m_halted;
  logic [31:0] m_cnt;

  function automatic logic [31:0] im_word(input logic [31:0] p);
    return 32'h1000_0000 + ((p >> 2) & 32'h3FF);
  endfunction

  task automatic model_step();
    bit pop, issue;
    if (!rst) begin
      q.delete(); m_pc = RESET_PC; m_started = 0; m_halted = 0; m_cnt = 0;
    end else begin
      pop   = (q.size() != 0) && out_ready;
      issue = m_started && !m_halted && !redirect && (q.size() < DEPTH || pop);
      if (redirect) begin
        q.delete();
        m_pc = redirect_pc & ~32'h3;
        m_halted = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (issue) begin
          q.push_back('{inst: im_word(m_pc), pc: m_pc});
          m_pc  = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
        if (halt_req && m_started) m_halted = 1;
      end
      m_started = 1;
    end
  endtask

  task automatic model_check(input string name);
    bit act, e_read, e_valid;
    logic [9:0]  e_addr;
    logic [31:0] e_inst, e_pc, e_cnt;
    act     = rst && m_started;
    e_read  = act && !m_halted && !redirect && (q.size() < DEPTH || (q.size() != 0 && out_ready));
    e_addr  = act ? 10'((m_pc >> 2) & 32'h3FF) : 10'h0;
    e_valid = rst && (q.size() != 0);
    e_inst  = e_valid ? q[0].inst : 32'h0;
    e_pc    = e_valid ? q[0].pc   : 32'h0;
`ifdef IF_FETCH_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 32'h0;
`endif
    n_tests++;
    if (IM_read !== e_read || IM_addr !== e_addr || out_valid !== e_valid ||
        out_inst !== e_inst || out_pc !== e_pc || fetch_cnt !== e_cnt) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got rd=%b addr=%h v=%b inst=%h pc=%h cnt=%0d want rd=%b addr=%h v=%b inst=%h pc=%h cnt=%0d",
               name, cyc, IM_read, IM_addr, out_valid, out_inst, out_pc, fetch_cnt,
               e_read, e_addr, e_valid, e_inst, e_pc, e_cnt);
    end
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc, input bit h);
    rst = r; out_ready = rdy; redirect = rd; redirect_pc = rpc; halt_req = h;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit rst; bit rdy; bit redir; logic [31:0] rpc; bit halt;
    bit e_read; logic [9:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc, input bit h,
                     input bit er, input logic [9:0] ea, input bit ev, input logic [31:0] ep);
    vecs.push_back('{rst: r, rdy: rdy, redir: rd, rpc: rpc, halt: h,
                     e_read: er, e_addr: ea, e_valid: ev, e_pc: ep});
  endtask

  initial begin
    logic [31:0] e_inst;
    // startup with decode always ready
    add(0,1,0,0,0, 0,10'h000,0,32'h0);
    add(1,1,0,0,0, 0,10'h000,0,32'h0);
    add(1,1,0,0,0, 1,10'h000,0,32'h0);
    add(1,1,0,0,0, 1,10'h001,1,32'h0);
    add(1,1,0,0,0, 1,10'h002,1,32'h4);
    add(1,1,0,0,0, 1,10'h003,1,32'h8);
    // stall until full, then one pop+push
    add(0,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h001,1,32'h0);
    add(1,0,0,0,0, 1,10'h002,1,32'h0);
    add(1,0,0,0,0, 1,10'h003,1,32'h0);
    add(1,0,0,0,0, 0,10'h004,1,32'h0);
    add(1,0,0,0,0, 0,10'h004,1,32'h0);
    add(1,1,0,0,0, 1,10'h004,1,32'h0);
    add(1,0,0,0,0, 0,10'h005,1,32'h4);
    // redirect with 3 buffered
    add(0,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h001,1,32'h0);
    add(1,0,0,0,0, 1,10'h002,1,32'h0);
    add(1,0,1,32'h0000_0103,0, 0,10'h003,1,32'h0);
    add(1,0,0,0,0, 1,10'h040,0,32'h0);
    add(1,1,0,0,0, 1,10'h041,1,32'h100);
    add(1,1,0,0,0, 1,10'h042,1,32'h104);
    // halt, drain, resume by redirect, halt+redirect together
    add(0,1,0,0,0, 0,10'h000,0,32'h0);
    add(1,1,0,0,0, 0,10'h000,0,32'h0);
    add(1,1,0,0,0, 1,10'h000,0,32'h0);
    add(1,1,0,0,1, 1,10'h001,1,32'h0);
    add(1,1,0,0,0, 0,10'h002,1,32'h4);
    add(1,1,0,0,0, 0,10'h002,0,32'h0);
    add(1,1,0,0,0, 0,10'h002,0,32'h0);
    add(1,1,1,32'h20,0, 0,10'h002,0,32'h0);
    add(1,1,0,0,0, 1,10'h008,0,32'h0);
    add(1,1,1,32'h43,1, 0,10'h009,1,32'h20);
    add(1,1,0,0,0, 1,10'h010,0,32'h0);
    add(1,1,0,0,0, 1,10'h011,1,32'h40);
    // reset while full with redirect asserted
    add(0,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h000,0,32'h0);
    add(1,0,0,0,0, 1,10'h001,1,32'h0);
    add(1,0,0,0,0, 1,10'h002,1,32'h0);
    add(1,0,0,0,0, 1,10'h003,1,32'h0);
    add(1,0,0,0,0, 0,10'h004,1,32'h0);
    add(0,0,1,32'h80,0, 0,10'h000,0,32'h0);
    add(1,0,0,0,0, 0,10'h000,0,32'h0);
    add(1,1,0,0,0, 1,10'h000,0,32'h0);
    // PC wrap at top of address space
    add(1,1,1,32'hFFFF_FFFE,0, 0,10'h001,1,32'h0);
    add(1,1,0,0,0, 1,10'h3FF,0,32'h0);
    add(1,1,0,0,0, 1,10'h000,1,32'hFFFF_FFFC);

    drive(0,0,0,0,0);
    advance();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      #2;
      e_inst = vecs[i].e_valid ? 32'h1000_0000 + {20'b0, vecs[i].e_pc[11:2]} : 32'h0;
      n_tests++;
      if (IM_read !== vecs[i].e_read || IM_addr !== vecs[i].e_addr || out_valid !== vecs[i].e_valid ||
          out_pc !== vecs[i].e_pc || out_inst !== e_inst) begin
        n_fail++;
        $display("FAIL vec%0d got rd=%b addr=%h v=%b pc=%h inst=%h want rd=%b addr=%h v=%b pc=%h inst=%h",
                 i, IM_read, IM_addr, out_valid, out_pc, out_inst,
                 vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc, e_inst);
      end
      model_check($sformatf("vec%0d_model", i));
      advance();
    end

    // fetch counter: 10 pushes then a redirect
    drive(0,1,0,0,0); #2; model_check("cnt_rst"); advance();
    drive(1,1,0,0,0); #2; model_check("cnt_wait"); advance();
    for (int k = 0; k < 10; k++) begin
      #2; model_check("cnt_run"); advance();
    end
    drive(1,1,1,32'h200,0); #2; model_check("cnt_redir"); advance();
    drive(1,0,0,0,0); #2;
    n_tests++;
`ifdef IF_FETCH_CNT_EN
    if (fetch_cnt !== 32'd10) begin
      n_fail++;
      $display("FAIL fetch_cnt got %0d want 10", fetch_cnt);
    end
`else
    if (fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL fetch_cnt got %0d want 0", fetch_cnt);
    end
`endif
    advance();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 15) == 0));
      #2;
      model_check("rand");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
